// File: rtl/ez8_prog_loader.sv
// Program loader and run supervisor for ez8_cpu: takes a framed byte stream, writes
// instruction memory with the CPU paused, then resets and runs the CPU and reports pass/fail.
module ez8_prog_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int MAX_WORDS      = 4096,
    parameter int RESET_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] instr_writeaddr,
    output logic [15:0]           instr_writedata,
    output logic                  instr_write_en,
    output logic                  cpu_pause,
    output logic                  cpu_reset,
    input  logic                  cpu_stopped,
    input  logic                  cpu_error,
    input  logic [7:0]            cpu_accum,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CSUM    = 4'd6;
    localparam logic [3:0] S_RST     = 4'd7;
    localparam logic [3:0] S_RUN     = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
    localparam logic [3:0] S_FAIL    = 4'd10;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_LENGTH  = 2'd1;
    localparam logic [1:0] FAIL_CSUM    = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [7:0]       len_hi;
    logic [15:0]      len;
    logic [7:0]       word_hi;
    logic [15:0]      word_cnt;
    logic [7:0]       csum;
    logic [RST_W-1:0] rst_cnt;
    logic [RUN_W-1:0] run_cnt;

    logic        take;
    logic [15:0] len_rx;
    logic        len_bad;
    logic        idle_like;

    assign take      = rx_valid && rx_ready;
    assign len_rx    = {len_hi, rx_data};
    assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > MAX_LEN);
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);

    function automatic logic is_rx_state(input logic [3:0] s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CSUM);
    endfunction

    function automatic logic is_cpu_live(input logic [3:0] s);
        return (s == S_RST) || (s == S_RUN);
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) state_next = S_LEN_HI;
            S_LEN_HI:  if (take) state_next = S_LEN_LO;
            S_LEN_LO:  if (take) state_next = len_bad ? S_FAIL : S_DATA_HI;
            S_DATA_HI: if (take) state_next = S_DATA_LO;
            S_DATA_LO: if (take) state_next = S_WRITE;
            S_WRITE:   state_next = (word_cnt + 16'd1 == len) ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (take) state_next = (rx_data == csum) ? S_RST : S_FAIL;
            S_RST:     if (rst_cnt == RST_LAST) state_next = S_RUN;
            S_RUN: begin
                // A stop on the final allowed cycle still counts as a finished run.
                if (cpu_stopped)              state_next = S_DONE;
                else if (run_cnt == RUN_LAST) state_next = S_FAIL;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            rx_ready        <= 1'b0;
            instr_write_en  <= 1'b0;
            instr_writeaddr <= '0;
            instr_writedata <= '0;
            cpu_pause       <= 1'b1;
            cpu_reset       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_code       <= FAIL_NONE;
            len_hi          <= '0;
            len             <= '0;
            word_hi         <= '0;
            word_cnt        <= '0;
            csum            <= '0;
            rst_cnt         <= '0;
            run_cnt         <= '0;
        end else begin
            state          <= state_next;
            rx_ready       <= is_rx_state(state_next);
            instr_write_en <= (state_next == S_WRITE);
            cpu_pause      <= !is_cpu_live(state_next);
            cpu_reset      <= (state_next == S_RST);
            busy           <= !((state_next == S_IDLE) || (state_next == S_DONE) ||
                                (state_next == S_FAIL));
            done           <= (state_next == S_DONE) || (state_next == S_FAIL);

            if (idle_like && start) begin
                word_cnt  <= '0;
                csum      <= '0;
                pass      <= 1'b0;
                fail_code <= FAIL_NONE;
                instr_writeaddr <= '0;
            end

            case (state)
                S_LEN_HI: if (take) begin
                    len_hi <= rx_data;
                    csum   <= csum + rx_data;
                end
                S_LEN_LO: if (take) begin
                    len  <= len_rx;
                    csum <= csum + rx_data;
                    if (len_bad) fail_code <= FAIL_LENGTH;
                end
                S_DATA_HI: if (take) begin
                    word_hi <= rx_data;
                    csum    <= csum + rx_data;
                end
                S_DATA_LO: if (take) begin
                    csum            <= csum + rx_data;
                    instr_writeaddr <= ADDR_WIDTH'(word_cnt);
                    instr_writedata <= {word_hi, rx_data};
                end
                S_WRITE: word_cnt <= word_cnt + 16'd1;
                S_CSUM: if (take) begin
                    rst_cnt <= '0;
                    if (rx_data != csum) fail_code <= FAIL_CSUM;
                end
                S_RST: begin
                    rst_cnt <= rst_cnt + RST_W'(1);
                    run_cnt <= '0;
                end
                S_RUN: begin
                    if (cpu_stopped) begin
                        pass <= !cpu_error && (cpu_accum == 8'd0);
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                        if (run_cnt == RUN_LAST) fail_code <= FAIL_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ez8_prog_loader.sv
// Bench for ez8_prog_loader: random and directed frames against a frame-level model,
// with a per-cycle compare of instruction writes and CPU control activity.
module tb_ez8_prog_loader;

    localparam int AW   = 12;
    localparam int MAXW = 4096;
    localparam int RSTC = 2;
    localparam int TO   = 100;

    typedef logic [7:0]  bytes_t[$];
    typedef logic [15:0] words_t[$];

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] instr_writeaddr;
    logic [15:0]   instr_writedata;
    logic          instr_write_en;
    logic          cpu_pause;
    logic          cpu_reset;
    logic          cpu_stopped;
    logic          cpu_error;
    logic [7:0]    cpu_accum;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;

    ez8_prog_loader #(
        .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .RESET_CYCLES(RSTC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .instr_writeaddr(instr_writeaddr), .instr_writedata(instr_writedata),
        .instr_write_en(instr_write_en),
        .cpu_pause(cpu_pause), .cpu_reset(cpu_reset),
        .cpu_stopped(cpu_stopped), .cpu_error(cpu_error), .cpu_accum(cpu_accum),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected writes {addr, data}; main appends, the compare process reads in order.
    logic [AW+15:0] exp_q[$];
    int got_n     = 0;
    int rst_total = 0;
    int run_total = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (instr_write_en) begin
                    if (got_n >= exp_q.size()) begin
                        check("write_count", 32'(got_n + 1), 32'(exp_q.size()));
                    end else begin
                        check("wr_addr", 32'(instr_writeaddr), 32'(exp_q[got_n][AW+15:16]));
                        check("wr_data", 32'(instr_writedata), 32'(exp_q[got_n][15:0]));
                        check("wr_paused", 32'(cpu_pause), 32'd1);
                        check("wr_rx_ready", 32'(rx_ready), 32'd0);
                    end
                    got_n++;
                end
                if (cpu_reset) begin
                    rst_total++;
                    check("rst_unpaused", 32'(cpu_pause), 32'd0);
                end
                if (!cpu_pause && !cpu_reset) run_total++;
            end
        end
    end

    // CPU model: counts running cycles and raises stopped once the programmed count is reached.
    bit stop_en    = 1'b0;
    int stop_after = 1;
    int cpu_cnt    = 0;
    initial begin
        cpu_stopped = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_pause || cpu_reset) cpu_cnt = 0;
            else cpu_cnt++;
            cpu_stopped = stop_en && !cpu_pause && !cpu_reset && (cpu_cnt >= stop_after);
        end
    end

    function automatic bytes_t frame_of(input words_t w, input logic [7:0] csum_delta);
        bytes_t f;
        logic [15:0] n;
        logic [7:0] s;
        n = 16'(w.size());
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
        foreach (w[i]) begin
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
        end
        s = 8'd0;
        foreach (f[i]) s = s + f[i];
        f.push_back(s + csum_delta);
        return f;
    endfunction

    // Frame-level outcome: length rule, checksum rule, then CPU verdict or timeout.
    function automatic void model(input bytes_t f, input bit stops, input logic err,
                                  input logic [7:0] acc, output int code, output bit pas,
                                  output int nw, output int nbytes);
        int len;
        int sum;
        len = int'({f[0], f[1]});
        pas = 1'b0;
        nw  = 0;
        if (len == 0 || len > MAXW) begin
            code   = 1;
            nbytes = 2;
            return;
        end
        nw     = len;
        nbytes = 3 + 2 * len;
        sum    = 0;
        for (int i = 0; i < 2 + 2 * len; i++) sum += int'(f[i]);
        if (int'(f[2 + 2 * len]) != sum % 256) code = 2;
        else if (!stops) code = 3;
        else begin
            code = 0;
            pas  = !err && (acc == 8'd0);
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_bytes(input bytes_t f, input bit gaps, input int start_at,
                               output int consumed);
        int idx = 0;
        int cyc = 0;
        while (idx < f.size() && !done && cyc < 20000) begin
            start = (idx == start_at);
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = f[idx];
                if (rx_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        consumed = idx;
    endtask

    task automatic run_frame(input string tag, input bytes_t f, input bit gaps, input bit stops,
                             input int stop_n, input logic err, input logic [7:0] acc,
                             input int start_at);
        int code, nw, nb, consumed, waited, r0, u0, exp_rst, exp_run;
        bit pas;
        model(f, stops, err, acc, code, pas, nw, nb);
        for (int k = 0; k < nw; k++) exp_q.push_back({AW'(k), f[2 + 2 * k], f[3 + 2 * k]});
        stop_en    = stops;
        stop_after = stop_n;
        cpu_error  = err;
        cpu_accum  = acc;
        r0 = rst_total;
        u0 = run_total;
        pulse_start();
        drive_bytes(f, gaps, start_at, consumed);
        waited = 0;
        while (!done && waited < TO + 500) begin
            @(negedge clk);
            waited++;
        end
        exp_rst = (code == 0 || code == 3) ? RSTC : 0;
        exp_run = (code == 0) ? stop_n : (code == 3) ? TO : 0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pass"}, 32'(pass), 32'(pas));
        check({tag, "_fail_code"}, 32'(fail_code), 32'(code));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pause"}, 32'(cpu_pause), 32'd1);
        check({tag, "_consumed"}, 32'(consumed), 32'(nb));
        check({tag, "_writes"}, 32'(got_n), 32'(exp_q.size()));
        check({tag, "_rst_cycles"}, 32'(rst_total - r0), 32'(exp_rst));
        check({tag, "_run_cycles"}, 32'(run_total - u0), 32'(exp_run));
        if (code == 1) check({tag, "_len_fail_latency"}, 32'(waited), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bytes_t f1, f2, f4, f6, part, fl;
        words_t w;
        int code, nw, nb, consumed;
        bit pas;

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_error = 1'b0; cpu_accum = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_write_en", 32'(instr_write_en), 32'd0);
        check("rst_addr", 32'(instr_writeaddr), 32'd0);
        check("rst_data", 32'(instr_writedata), 32'd0);
        check("rst_pause", 32'(cpu_pause), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail_code", 32'(fail_code), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Two-word frame: checksum of 00 02 12 34 AB CD is 0xC0.
        w = '{16'h1234, 16'hABCD};
        f1 = frame_of(w, 8'd0);
        check("t1_frame_csum", 32'(f1[6]), 32'hC0);
        model(f1, 1'b1, 1'b0, 8'h00, code, pas, nw, nb);
        check("t1_model_code", 32'(code), 32'd0);
        check("t1_model_pass", 32'(pas), 32'd1);
        run_frame("t1", f1, 1'b0, 1'b1, 5, 1'b0, 8'h00, -1);

        f2 = f1;
        f2[6] = 8'hC1;
        model(f2, 1'b1, 1'b0, 8'h00, code, pas, nw, nb);
        check("t2_model_code", 32'(code), 32'd2);
        run_frame("t2", f2, 1'b0, 1'b1, 5, 1'b0, 8'h00, -1);

        fl = '{8'h00, 8'h00};
        run_frame("t3_len0", fl, 1'b0, 1'b1, 5, 1'b0, 8'h00, -1);
        fl = '{8'h10, 8'h01};
        run_frame("t3_len4097", fl, 1'b0, 1'b1, 5, 1'b0, 8'h00, -1);
        fl = '{8'h10, 8'h00};
        pulse_start();
        drive_bytes(fl, 1'b0, -1, consumed);
        check("t3_len4096_consumed", 32'(consumed), 32'd2);
        check("t3_len4096_done", 32'(done), 32'd0);
        check("t3_len4096_ready", 32'(rx_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        w = {};
        for (int i = 0; i < 16; i++) w.push_back(16'($urandom));
        f4 = frame_of(w, 8'd0);
        run_frame("t4_nogap", f4, 1'b0, 1'b1, 3, 1'b0, 8'h00, -1);
        run_frame("t4_gap", f4, 1'b1, 1'b1, 7, 1'b0, 8'h00, 7);

        run_frame("t5_timeout", f1, 1'b0, 1'b0, 1, 1'b0, 8'h00, -1);
        run_frame("t5_accum", f1, 1'b0, 1'b1, 4, 1'b0, 8'h05, -1);
        run_frame("t5_error", f1, 1'b1, 1'b1, 2, 1'b1, 8'h00, -1);

        w = {};
        for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
        f6 = frame_of(w, 8'd0);
        part = {};
        for (int i = 0; i < 9; i++) part.push_back(f6[i]);
        for (int k = 0; k < 3; k++) exp_q.push_back({AW'(k), f6[2 + 2 * k], f6[3 + 2 * k]});
        stop_en = 1'b1; stop_after = 3; cpu_error = 1'b0; cpu_accum = 8'h00;
        pulse_start();
        drive_bytes(part, 1'b0, -1, consumed);
        check("t6_consumed", 32'(consumed), 32'd9);
        check("t6_in_data_lo", 32'(rx_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_abort_write_en", 32'(instr_write_en), 32'd0);
        check("t6_abort_pause", 32'(cpu_pause), 32'd1);
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_writes_before_abort", 32'(got_n), 32'(exp_q.size()));
        run_frame("t6_reload", f6, 1'b1, 1'b1, 3, 1'b0, 8'h00, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
